// File: rtl/dadda_ctrl_pkg.sv
// Shared types and constants for the arbitrated approximate 8x8 Dadda multiplier.
// Request/response records carry a requester ID sized for the largest legal N_REQ (8).
package dadda_ctrl_pkg;

    localparam int OP_W     = 8;
    localparam int MASK_W   = 16;
    localparam int RES_W    = 17;
    localparam int PP_W     = 2 * OP_W;
    localparam int ID_MAX_W = 3;

    // Each mask bit keeps or drops one partial-product column; all ones is exact.
    localparam logic [MASK_W-1:0] EXACT_M = 16'hFFFF;

    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [MASK_W-1:0]   m;
        logic [ID_MAX_W-1:0] id;
    } mul_req_t;

    typedef struct packed {
        logic [RES_W-1:0]    res;
        logic [ID_MAX_W-1:0] id;
    } mul_rsp_t;

    typedef struct packed {
        logic [PP_W-1:0] s;
        logic [PP_W-1:0] c;
    } csa_t;

    // 3:2 carry-save compressor over whole rows.
    function automatic csa_t csa3(input logic [PP_W-1:0] x,
                                  input logic [PP_W-1:0] y,
                                  input logic [PP_W-1:0] z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/dadda8_CLA.sv
// Approximate 8x8 multiplier: masked partial products, Dadda-height reduction (8-6-4-3-2)
// and a 16-bit carry-lookahead final adder producing a 17-bit result.
module dadda8_CLA
    import dadda_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [MASK_W-1:0] m,
    output logic [RES_W-1:0]  res
);

    logic [PP_W-1:0] pp [OP_W];
    csa_t l1a, l1b, l2a, l2b, l3, l4;

    always_comb begin
        for (int j = 0; j < OP_W; j++) begin
            pp[j] = (PP_W'(a & {OP_W{b[j]}}) << j) & m;
        end
    end

    assign l1a = csa3(pp[0], pp[1], pp[2]);
    assign l1b = csa3(pp[3], pp[4], pp[5]);
    assign l2a = csa3(l1a.s, l1a.c, l1b.s);
    assign l2b = csa3(l1b.c, pp[6], pp[7]);
    assign l3  = csa3(l2a.s, l2a.c, l2b.s);
    assign l4  = csa3(l3.s, l3.c, l2b.c);

    // Two-level lookahead: group generate/propagate across four 4-bit groups.
    function automatic logic [RES_W-1:0] cla16(input logic [PP_W-1:0] x,
                                               input logic [PP_W-1:0] y);
        logic [PP_W-1:0] g, p, c;
        logic [3:0]      gg, pg, gc;
        logic            cout;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
        gc[0] = 1'b0;
        gc[1] = gg[0];
        gc[2] = gg[1] | (pg[1] & gg[0]);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]);
        cout  = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        return {cout, p ^ c};
    endfunction

    assign res = cla16(l4.s, l4.c);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr and wraps; pointer moves past each grant.
// Grants are only issued while en is high.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] rr_ptr;
    logic            found;
    int              idx;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding (no latch).
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        gnt = '0;
        if (en && found) gnt[gnt_id] = 1'b1;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (en && found) begin
            rr_ptr <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/dadda8_mul_arbiter.sv
// Shares one dadda8_CLA among N_REQ requesters: round-robin grant into s1, multiply,
// register into s2, return tagged responses in grant order.
module dadda8_mul_arbiter
    import dadda_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*OP_W-1:0]   req_a,
    input  logic [N_REQ*OP_W-1:0]   req_b,
    input  logic [N_REQ*MASK_W-1:0] req_m,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_res
);

    logic             s1_valid, s2_valid;
    mul_req_t         s1_req, in_req;
    mul_rsp_t         s2_rsp;
    logic             adv, arb_en;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [RES_W-1:0] mul_res;

    assign adv    = !s2_valid || rsp_ready;
    assign arb_en = adv && rst_n;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;

    always_comb begin
        in_req.a  = req_a[int'(gnt_id)*OP_W +: OP_W];
        in_req.b  = req_b[int'(gnt_id)*OP_W +: OP_W];
        in_req.m  = req_m[int'(gnt_id)*MASK_W +: MASK_W];
        in_req.id = ID_MAX_W'(gnt_id);
    end

    // The multiplier sits alone between the s1 and s2 registers.
    dadda8_CLA u_mul (
        .a   (s1_req.a),
        .b   (s1_req.b),
        .m   (s1_req.m),
        .res (mul_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s2_valid <= 1'b0;
            s2_rsp   <= '0;
        end else if (adv) begin
            s2_valid   <= s1_valid;
            s2_rsp.res <= mul_res;
            s2_rsp.id  <= s1_req.id;
            s1_valid   <= |gnt;
            if (|gnt) s1_req <= in_req;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_rsp.id[ID_W-1:0];
    assign rsp_res   = s2_rsp.res;

    // Upper ID bits are spare when N_REQ is below the maximum.
    logic unused_id_bits;
    assign unused_id_bits = ^s2_rsp.id;

endmodule

// File: tb/tb_dadda8_mul_arbiter.sv
// Scoreboard bench for dadda8_mul_arbiter: accepts push expected responses, a separate
// monitor pops and compares each consumed response.
module tb_dadda8_mul_arbiter;
    import dadda_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*8-1:0]  req_a, req_b;
    logic [N*16-1:0] req_m;
    logic            rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [16:0]     rsp_res;

    always #5 clk = ~clk;

    dadda8_mul_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res)
    );

    typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] m; logic [16:0] exp; } stim_t;
    typedef struct { logic [IW-1:0] id; logic [16:0] res; } exp_t;

    stim_t    stim_q [N][$];
    stim_t    cur [N];
    exp_t     sb_q [$];
    int       gnt_log [$];
    int       rsp_cyc_log [$];
    int       rsp_id_log [$];
    logic [N-1:0] acc_mask;
    int       cyc = 0;
    int       n_pass = 0;
    int       n_total = 0;
    logic     rand_bp = 1'b0;

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_m = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8]   = cur[i].a;
            req_b[i*8 +: 8]   = cur[i].b;
            req_m[i*16 +: 16] = cur[i].m;
        end
    end

    function automatic logic [16:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic [15:0] m);
        int s = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (m[i+j] && a[i] && b[j]) s += (1 << (i + j));
        return 17'(s);
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic push_stim(input int r, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] m, input logic [16:0] e);
        stim_q[r].push_back('{a: a, b: b, m: m, exp: e});
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Driver: present the next queued operands once the current ones are accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && stim_q[i].size() > 0) begin
                cur[i] = stim_q[i].pop_front();
                req_valid[i] = 1'b1;
            end
        end
        acc_mask = '0;
    end

    // Issue side: each accept pushes its expected response.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_mask[i] = 1'b1;
                sb_q.push_back('{id: IW'(i), res: cur[i].exp});
                gnt_log.push_back(i);
            end
        end
    end

    // Response side: every consumed response is compared against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check(1'b0, "rsp_unexpected", rsp_id, -1);
            end else begin
                e = sb_q.pop_front();
                check(rsp_id == e.id, "rsp_id", rsp_id, e.id);
                check(rsp_res == e.res, "rsp_res", rsp_res, e.res);
            end
            rsp_cyc_log.push_back(cyc);
            rsp_id_log.push_back(int'(rsp_id));
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic bit busy();
        bit b = (req_valid != '0) || (sb_q.size() != 0);
        for (int i = 0; i < N; i++) if (stim_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            @(negedge clk);
            k++;
        end
        #3;
        check(!busy(), name, sb_q.size(), 0);
    endtask

    task automatic wait_grants(input string name, input int target, input int budget);
        int k = 0;
        while (gnt_log.size() < target && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(gnt_log.size() >= target, name, gnt_log.size(), target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, r0, first, r;
        logic [7:0]  a, b;
        logic [15:0] m;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        acc_mask  = '0;
        for (int i = 0; i < N; i++) cur[i] = '{a: 8'd0, b: 8'd0, m: 16'd0, exp: 17'd0};
        req_valid = '1;

        // Reset state, with every requester asking.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check(req_ready == '0, "rst_ready", req_ready, 0);
        check(rsp_valid == 1'b0, "rst_rsp_valid", rsp_valid, 0);
        check(rsp_id == '0, "rst_rsp_id", rsp_id, 0);
        check(rsp_res == 17'd0, "rst_rsp_res", rsp_res, 0);
        @(posedge clk);
        #2 req_valid = '0;
        rst_n = 1'b1;

        // Single request on requester 2.
        push_stim(2, 8'd200, 8'd150, EXACT_M, 17'd30000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            if (req_ready[2]) break;
        end
        check(req_ready == 4'b0100, "single_ready", req_ready, 4);
        @(negedge clk);
        #2 check(rsp_valid == 1'b0, "single_lat1", rsp_valid, 0);
        @(negedge clk);
        #2;
        check(rsp_valid == 1'b1, "single_valid", rsp_valid, 1);
        check(rsp_id == 2'd2, "single_id", rsp_id, 2);
        check(rsp_res == 17'd30000, "single_res", rsp_res, 30000);
        @(negedge clk);
        #2 check(rsp_valid == 1'b0, "single_after", rsp_valid, 0);
        wait_drain("single_drain", 50);

        // Fairness: all four requesters continuously valid.
        do_reset();
        g0 = gnt_log.size();
        r0 = rsp_cyc_log.size();
        for (int rep = 0; rep < 3; rep++)
            for (int i = 0; i < N; i++) begin
                a = 8'(10 * (i + 1) + rep);
                b = 8'(3 + i + rep);
                push_stim(i, a, b, EXACT_M, 17'(int'(a) * int'(b)));
            end
        wait_drain("fair_drain", 200);
        check(gnt_log.size() - g0 == 12, "fair_grants", gnt_log.size() - g0, 12);
        if (gnt_log.size() - g0 == 12 && rsp_cyc_log.size() - r0 == 12) begin
            for (int k = 0; k < 12; k++) begin
                check(gnt_log[g0+k] == k % 4, "fair_gnt_order", gnt_log[g0+k], k % 4);
                check(rsp_id_log[r0+k] == k % 4, "fair_rsp_order", rsp_id_log[r0+k], k % 4);
                if (k > 0)
                    check(rsp_cyc_log[r0+k] == rsp_cyc_log[r0+k-1] + 1, "fair_b2b",
                          rsp_cyc_log[r0+k], rsp_cyc_log[r0+k-1] + 1);
            end
        end

        // Backpressure with two requests in flight.
        do_reset();
        g0 = gnt_log.size();
        r0 = rsp_cyc_log.size();
        push_stim(1, 8'd12, 8'd34, EXACT_M, 17'd408);
        push_stim(3, 8'd255, 8'd255, 16'h00FF, 17'd1793);
        wait_grants("bp_grants", g0 + 2, 20);
        @(posedge clk);
        #2 rsp_ready = 1'b0;
        push_stim(0, 8'd255, 8'd1, EXACT_M, 17'd255);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            check(rsp_valid == 1'b1, "bp_valid", rsp_valid, 1);
            check(rsp_id == 2'd1, "bp_id", rsp_id, 1);
            check(rsp_res == 17'd408, "bp_res", rsp_res, 408);
            check(req_ready == '0, "bp_no_accept", req_ready, 0);
        end
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        wait_drain("bp_drain", 50);
        check(rsp_cyc_log.size() - r0 == 3, "bp_count", rsp_cyc_log.size() - r0, 3);
        if (rsp_cyc_log.size() - r0 == 3) begin
            check(rsp_id_log[r0] == 1 && rsp_id_log[r0+1] == 3 && rsp_id_log[r0+2] == 0,
                  "bp_order", rsp_id_log[r0] * 100 + rsp_id_log[r0+1] * 10 + rsp_id_log[r0+2], 130);
            check(rsp_cyc_log[r0+1] == rsp_cyc_log[r0] + 1, "bp_consecutive",
                  rsp_cyc_log[r0+1] - rsp_cyc_log[r0], 1);
            check(rsp_cyc_log[r0+2] == rsp_cyc_log[r0] + 2, "bp_accept_on_release",
                  rsp_cyc_log[r0+2] - rsp_cyc_log[r0], 2);
        end

        // Approximate masks: directed corners, then random traffic with random backpressure.
        do_reset();
        push_stim(2, 8'd255, 8'd255, 16'h00FF, 17'd1793);
        push_stim(2, 8'd255, 8'd255, 16'hFF00, 17'd63232);
        push_stim(2, 8'd255, 8'd255, 16'h0000, 17'd0);
        push_stim(1, 8'd255, 8'd255, EXACT_M, 17'd65025);
        push_stim(0, 8'd0, 8'd255, EXACT_M, 17'd0);
        rand_bp = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            r = $urandom_range(0, N - 1);
            a = 8'($urandom);
            b = 8'($urandom);
            m = 16'($urandom);
            push_stim(r, a, b, m, ref_mul(a, b, m));
        end
        wait_drain("rand_drain", 20000);
        rand_bp = 1'b0;
        @(posedge clk);
        #2 rsp_ready = 1'b1;

        // Reset while s1 and s2 both hold work.
        do_reset();
        rsp_ready = 1'b0;
        g0 = gnt_log.size();
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N; i++)
                push_stim(i, 8'(7 + i), 8'(9 + rep), EXACT_M, 17'((7 + i) * (9 + rep)));
        wait_grants("full_grants", g0 + 2, 20);
        @(negedge clk);
        #2;
        check(req_ready == '0, "full_no_accept", req_ready, 0);
        check(rsp_valid == 1'b1, "full_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 check(req_ready == '0, "rst_mid_ready", req_ready, 0);
        @(posedge clk);
        #2;
        sb_q.delete();
        g1 = gnt_log.size();
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check(rsp_valid == 1'b0, "rst_flush", rsp_valid, 0);
        first = (gnt_log.size() > g1) ? gnt_log[g1] : -1;
        check(first == 0, "rst_first_grant", first, 0);
        wait_drain("rst_drain", 100);

        // Pointer wrap: grant 2 moves the pointer to 3, then 3 and 0 compete.
        do_reset();
        push_stim(2, 8'd5, 8'd6, EXACT_M, 17'd30);
        wait_drain("wrap_pre_drain", 50);
        g0 = gnt_log.size();
        push_stim(3, 8'd11, 8'd13, EXACT_M, 17'd143);
        push_stim(3, 8'd17, 8'd19, EXACT_M, 17'd323);
        push_stim(0, 8'd23, 8'd29, EXACT_M, 17'd667);
        push_stim(0, 8'd31, 8'd37, EXACT_M, 17'd1147);
        wait_drain("wrap_drain", 50);
        check(gnt_log.size() - g0 == 4, "wrap_count", gnt_log.size() - g0, 4);
        if (gnt_log.size() - g0 == 4) begin
            check(gnt_log[g0] == 3, "wrap_g0", gnt_log[g0], 3);
            check(gnt_log[g0+1] == 0, "wrap_g1", gnt_log[g0+1], 0);
            check(gnt_log[g0+2] == 3, "wrap_g2", gnt_log[g0+2], 3);
            check(gnt_log[g0+3] == 0, "wrap_g3", gnt_log[g0+3], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
